// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle RV32I control path.
// Holds the control FSM state enum, opcode constants, the immediate-type
// encoding used by the immediate generator, ALU/result mux selects, the
// ALU operation encoding and the opcode-to-immediate-type decode.
// Optional feature macro: MULTICYCLE_CTRL_TRAP_EN (adds the TRAP state).
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    LUI       = 4'd11,
    AUIPC     = 4'd12
`ifdef MULTICYCLE_CTRL_TRAP_EN
    , TRAP    = 4'd13
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // alu_op: how the ALU decoder should pick the operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_I, OP_LOAD:    imm_decode = IMM_I;
      OP_STORE:         imm_decode = IMM_S;
      OP_BRANCH:        imm_decode = IMM_B;
      OP_LUI, OP_AUIPC: imm_decode = IMM_U;
      OP_JAL:           imm_decode = IMM_J;
      default:          imm_decode = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: purely combinational ALU operation decode.
// Ports:
//   alu_op   in  2 : ADD / SUB / funct-decoded request from the FSM
//   funct3   in  3 : IR[14:12]
//   funct7b5 in  1 : IR[30]
//   op5      in  1 : IR[5], distinguishes R-type from I-type
//   alu_ctrl out 3 : ALU operation encoding
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi never subtracts: op5 is 0 for I-type
          3'b000:  alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/write-back and drives every datapath
// enable and mux select. Memory uses a valid/ready handshake (mem_req held
// until mem_ready). Outputs are Moore except ir_write/pc_write in FETCH
// (follow mem_ready) and pc_write in BRANCH (zero ^ funct3[0]).
// All outputs are forced to 0 while rst_n is low.
// Ports:
//   clk, rst_n (sync, active low); op, funct3, funct7b5 from IR; zero from ALU;
//   mem_ready from memory; mem_req, mem_we, adr_src, ir_write, pc_write,
//   reg_write, alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal.
// Optional macro MULTICYCLE_CTRL_TRAP_EN: unsupported instructions enter a
// sticky TRAP state raising illegal; otherwise they execute as a 2-cycle NOP.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

`ifdef MULTICYCLE_CTRL_TRAP_EN
  localparam state_t ILL_NEXT = TRAP;
`else
  localparam state_t ILL_NEXT = FETCH;
`endif

  state_t     state, state_n;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl_raw;
  logic       branch_ok;

  // only beq/bne are supported
  assign branch_ok = (funct3[2:1] == 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      FETCH:     if (mem_ready) state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_n = MEM_ADR;
          OP_R:              state_n = EXEC_R;
          OP_I:              state_n = EXEC_I;
          OP_BRANCH:         state_n = branch_ok ? BRANCH : ILL_NEXT;
          OP_JAL:            state_n = JAL;
          OP_LUI:            state_n = LUI;
          OP_AUIPC:          state_n = AUIPC;
          default:           state_n = ILL_NEXT;
        endcase
      end
      MEM_ADR:   state_n = op[5] ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready) state_n = MEM_WB;
      MEM_WB:    state_n = FETCH;
      MEM_WRITE: if (mem_ready) state_n = FETCH;
      EXEC_R:    state_n = ALU_WB;
      EXEC_I:    state_n = ALU_WB;
      ALU_WB:    state_n = FETCH;
      BRANCH:    state_n = FETCH;
      JAL:       state_n = ALU_WB;
      LUI:       state_n = FETCH;
      AUIPC:     state_n = ALU_WB;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      TRAP:      state_n = TRAP;
`endif
      default:   state_n = FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
    imm_src    = imm_decode(op);
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEM_WB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALU_WB:    reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero ^ funct3[0];
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      TRAP:      illegal = 1'b1;
`endif
      default: ;
    endcase
    if (!rst_n) begin
      mem_req    = '0;
      mem_we     = '0;
      adr_src    = '0;
      ir_write   = '0;
      pc_write   = '0;
      reg_write  = '0;
      alu_src_a  = '0;
      alu_src_b  = '0;
      result_src = '0;
      imm_src    = '0;
      illegal    = '0;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .op5      (op[5]),
    .alu_ctrl (alu_ctrl_raw)
  );

  assign alu_ctrl = rst_n ? alu_ctrl_raw : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Drives instruction sequences with directed
// wait states and compares every cycle against a state-sequence model built
// from instruction class, plus literal pins on selected cycles.
// Honours MULTICYCLE_CTRL_TRAP_EN for the illegal-instruction expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src, alu_ctrl;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
    .illegal(illegal)
  );

  typedef struct packed {
    logic       mreq, we, adr, irw, pcw, rw;
    logic [1:0] a, b, rs;
    logic [2:0] imm, alu;
    logic       ill;
  } ov_t;

  ov_t   act, want, lit_mask, lit_val;
  logic  chk = 1'b0;
  logic  lit_on = 1'b0;
  string chk_name = "";
  int    vectors = 0;
  int    miscompares = 0;

  assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal};

  always @(negedge clk) begin
    if (chk) begin
      vectors++;
      if (act !== want) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", chk_name, act, want);
      end
    end
    if (lit_on) begin
      vectors++;
      if (((act ^ lit_val) & lit_mask) != '0) begin
        miscompares++;
        $display("FAIL %s pin: got %h want %h", chk_name, act & lit_mask, lit_val & lit_mask);
      end
    end
  end

  function automatic logic [2:0] m_imm(input logic [6:0] o);
    case (o)
      7'b0010011, 7'b0000011: return 3'b000;
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b0110111, 7'b0010111: return 3'b011;
      7'b1101111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] m_alu(input logic [2:0] f3, input logic f7, input logic o5);
    case (f3)
      3'b000:  return (f7 & o5) ? 3'b001 : 3'b000;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      3'b010:  return 3'b101;
      3'b001:  return 3'b110;
      3'b101:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ov_t expv(input string st, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input logic rdy);
    ov_t v;
    v = '0;
    v.imm = m_imm(o);
    if (st == "FETCH") begin
      v.mreq = 1'b1; v.b = 2'b10; v.rs = 2'b10; v.irw = rdy; v.pcw = rdy;
    end else if (st == "DECODE" || st == "AUIPC") begin
      v.a = 2'b01; v.b = 2'b01;
    end else if (st == "MEM_ADR") begin
      v.a = 2'b10; v.b = 2'b01;
    end else if (st == "MEM_READ") begin
      v.mreq = 1'b1; v.adr = 1'b1;
    end else if (st == "MEM_WB") begin
      v.rs = 2'b01; v.rw = 1'b1;
    end else if (st == "MEM_WRITE") begin
      v.mreq = 1'b1; v.we = 1'b1; v.adr = 1'b1;
    end else if (st == "EXEC_R") begin
      v.a = 2'b10; v.alu = m_alu(f3, f7, o[5]);
    end else if (st == "EXEC_I") begin
      v.a = 2'b10; v.b = 2'b01; v.alu = m_alu(f3, f7, o[5]);
    end else if (st == "ALU_WB") begin
      v.rw = 1'b1;
    end else if (st == "BRANCH") begin
      v.a = 2'b10; v.alu = 3'b001; v.pcw = z ^ f3[0];
    end else if (st == "JAL") begin
      v.a = 2'b01; v.b = 2'b10; v.pcw = 1'b1;
    end else if (st == "LUI") begin
      v.rs = 2'b11; v.rw = 1'b1;
    end else if (st == "TRAP") begin
      v.ill = 1'b1;
    end
    return v;
  endfunction

  task automatic cyc(input ov_t w, input string nm);
    want = w;
    chk_name = nm;
    chk = 1'b1;
    @(posedge clk);
    #1;
    lit_on = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw,
                           input string pin_st, input ov_t pmask, input ov_t pval);
    string seq[$];
    string st;
    int    waits;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    seq = {"FETCH", "DECODE"};
    case (o)
      7'b0000011: begin seq.push_back("MEM_ADR"); seq.push_back("MEM_READ"); seq.push_back("MEM_WB"); end
      7'b0100011: begin seq.push_back("MEM_ADR"); seq.push_back("MEM_WRITE"); end
      7'b0110011: begin seq.push_back("EXEC_R"); seq.push_back("ALU_WB"); end
      7'b0010011: begin seq.push_back("EXEC_I"); seq.push_back("ALU_WB"); end
      7'b1101111: begin seq.push_back("JAL"); seq.push_back("ALU_WB"); end
      7'b0110111: seq.push_back("LUI");
      7'b0010111: begin seq.push_back("AUIPC"); seq.push_back("ALU_WB"); end
      7'b1100011: if (f3 == 3'b000 || f3 == 3'b001) seq.push_back("BRANCH");
      default: ;
    endcase
`ifdef MULTICYCLE_CTRL_TRAP_EN
    if (seq.size() == 2) begin
      seq.push_back("TRAP"); seq.push_back("TRAP"); seq.push_back("TRAP");
    end
`endif
    foreach (seq[i]) begin
      st = seq[i];
      waits = (st == "FETCH") ? fw : ((st == "MEM_READ" || st == "MEM_WRITE") ? mw : 0);
      for (int k = 0; k < waits; k++) begin
        mem_ready = 1'b0;
        cyc(expv(st, o, f3, f7, z, 1'b0), $sformatf("%s-wait op=%b f3=%b", st, o, f3));
      end
      mem_ready = 1'b1;
      if (st == pin_st) begin
        lit_on = 1'b1; lit_mask = pmask; lit_val = pval;
      end
      cyc(expv(st, o, f3, f7, z, 1'b1), $sformatf("%s op=%b f3=%b", st, o, f3));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc('0, "reset-gated");
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ov_t m, v;
    op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc('0, "reset-gated");
    cyc('0, "reset-gated");
    rst_n = 1'b1;

    // first fetch after release: mem_req=1, adr_src=0, ir_write=pc_write=1
    m = '0; m.mreq = 1; m.adr = 1; m.irw = 1; m.pcw = 1;
    v = '0; v.mreq = 1; v.irw = 1; v.pcw = 1;
    run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0, "FETCH", m, v);

    // sub after 3 fetch wait states
    m = '0; m.alu = '1; v = '0; v.alu = 3'b001;
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 3, 0, "EXEC_R", m, v);

    m = '0; m.rs = '1; m.rw = 1; v = '0; v.rs = 2'b01; v.rw = 1;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, "MEM_WB", m, v);
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1, 2, "", '0, '0);

    m = '0; m.we = 1; m.imm = '1; v = '0; v.we = 1; v.imm = 3'b001;
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1, "MEM_WRITE", m, v);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, "", '0, '0);

    m = '0; m.pcw = 1; v = '0; v.pcw = 1;
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, "BRANCH", m, v);
    v.pcw = 0;
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, "BRANCH", m, v);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, "", '0, '0);
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, "", '0, '0);

    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, "", '0, '0);
    m = '0; m.imm = '1; m.rs = '1; m.rw = 1; v = '0; v.imm = 3'b011; v.rs = 2'b11; v.rw = 1;
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, "LUI", m, v);
    run_instr(7'b0010111, 3'b000, 1'b0, 1'b0, 0, 0, "", '0, '0);

    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, "", '0, '0);
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, "", '0, '0);
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0, "", '0, '0);
    run_instr(7'b0110011, 3'b100, 1'b0, 1'b0, 0, 0, "", '0, '0);
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, "", '0, '0);
    run_instr(7'b0110011, 3'b101, 1'b1, 1'b0, 0, 0, "", '0, '0);
    run_instr(7'b0010011, 3'b001, 1'b0, 1'b0, 0, 0, "", '0, '0);
    // addi with IR[30]=1 must still add
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, "", '0, '0);
    run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 0, 0, "", '0, '0);
    run_instr(7'b0010011, 3'b100, 1'b0, 1'b0, 0, 0, "", '0, '0);

    // reset while MEM_READ waits: request dropped, FETCH on release
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    cyc(expv("FETCH", op, funct3, 1'b0, 1'b0, 1'b1), "midrst FETCH");
    cyc(expv("DECODE", op, funct3, 1'b0, 1'b0, 1'b1), "midrst DECODE");
    cyc(expv("MEM_ADR", op, funct3, 1'b0, 1'b0, 1'b1), "midrst MEM_ADR");
    mem_ready = 1'b0;
    cyc(expv("MEM_READ", op, funct3, 1'b0, 1'b0, 1'b0), "midrst MEM_READ-wait");
    cyc(expv("MEM_READ", op, funct3, 1'b0, 1'b0, 1'b0), "midrst MEM_READ-wait");
    do_reset();
    m = '0; m.mreq = 1; m.adr = 1; v = '0; v.mreq = 1;
    lit_on = 1'b1; lit_mask = m; lit_val = v;
    cyc(expv("FETCH", op, funct3, 1'b0, 1'b0, 1'b0), "midrst FETCH-after");
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, "", '0, '0);

    // unsupported opcode, then unsupported branch funct3
    m = '0; m.ill = 1; v = '0; v.ill = 1;
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, "TRAP", m, v);
    do_reset();
    run_instr(7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0, "", '0, '0);
    do_reset();
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, "", '0, '0);

    chk = 1'b0;
    lit_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
